// File: rtl/panel_pkg.sv
// panel_pkg: constants shared by the front-panel display blocks.
//   SEG_x     - active-low {g,f,e,d,c,b,a} patterns for hex digits 0-F
//   SEG_BLANK - all segments off
//   AN_OFF    - all anodes off (active-low)
//   DIGITS    - number of digits on the display
package panel_pkg;

  localparam int DIGITS = 4;

  localparam logic [3:0] AN_OFF    = 4'b1111;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] SEG_A = 7'h08;
  localparam logic [6:0] SEG_B = 7'h03;  // lowercase b
  localparam logic [6:0] SEG_C = 7'h46;
  localparam logic [6:0] SEG_D = 7'h21;  // lowercase d
  localparam logic [6:0] SEG_E = 7'h06;
  localparam logic [6:0] SEG_F = 7'h0E;

  typedef logic [3:0] digit_t;

endpackage

// File: rtl/digit_entry_display_if.sv
// digit_entry_display_if: front-panel entry/display signal bundle.
//   clr, ent, sw          - entry controls (driven by the master)
//   AN, seven_out         - scanned display outputs, active-low
//   code, count, full     - packed buffer contents and fill status
// master: the panel top level; slave: digit_entry_display.
interface digit_entry_display_if;

  logic        clr;
  logic        ent;
  logic [3:0]  sw;
  logic [3:0]  AN;
  logic [6:0]  seven_out;
  logic [15:0] code;
  logic [2:0]  count;
  logic        full;

  modport master (
    output clr, ent, sw,
    input  AN, seven_out, code, count, full
  );

  modport slave (
    input  clr, ent, sw,
    output AN, seven_out, code, count, full
  );

endinterface

// File: rtl/hex_to_seven.sv
// hex_to_seven: combinational hex digit to seven-segment decoder.
//   digit - 4-bit hex value
//   seg   - active-low {g,f,e,d,c,b,a}; b and d use lowercase shapes
module hex_to_seven
  import panel_pkg::*;
(
  input  digit_t     digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    unique case (digit)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
    endcase
  end

endmodule

// File: rtl/digit_entry_display.sv
// digit_entry_display: four-digit hex entry buffer with a multiplexed
// seven-segment scan driver.
//   clk_in - system clock (rising edge)
//   rst    - asynchronous active-high reset
//   bus    - slave side of digit_entry_display_if:
//            clr/ent/sw in; AN/seven_out/code/count/full out
// REFRESH_DIV sets how many clk_in cycles each digit stays lit (>= 2).
module digit_entry_display
  import panel_pkg::*;
#(
  parameter int REFRESH_DIV = 100000
) (
  input  logic                 clk_in,
  input  logic                 rst,
  digit_entry_display_if.slave bus
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [2:0]    COUNT_MAX  = 3'(DIGITS);

  // Entry buffer: digit_reg[0] is the most recent entry (rightmost).
  logic [DIGITS-1:0][3:0] digit_reg, digit_next, digit_shifted;
  logic [DIGITS-1:0]      valid_reg, valid_next;
  logic [2:0]             count_reg, count_next;
  logic                   full_reg;

  // Scan state and registered display outputs.
  logic [PW-1:0] presc_reg;
  logic [1:0]    idx_reg;
  logic [3:0]    an_reg;
  logic [6:0]    seg_reg;

  digit_t     lit_digit;
  logic       lit_valid;
  logic [6:0] dec_seg;

  // Left-shift view of the buffer with the switch value entering at d0.
  // Once full, the oldest digit falls off the top (rolling window).
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_shift
    if (gi == 0) begin : g_in
      assign digit_shifted[gi] = bus.sw;
    end else begin : g_mid
      assign digit_shifted[gi] = digit_reg[gi-1];
    end
  end

  // clr wins over a simultaneous ent.
  always_comb begin
    digit_next = digit_reg;
    valid_next = valid_reg;
    count_next = count_reg;
    if (bus.clr) begin
      digit_next = '0;
      valid_next = '0;
      count_next = '0;
    end else if (bus.ent) begin
      digit_next = digit_shifted;
      valid_next = {valid_reg[DIGITS-2:0], 1'b1};
      count_next = (count_reg == COUNT_MAX) ? count_reg : count_reg + 3'd1;
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      digit_reg <= '0;
      valid_reg <= '0;
      count_reg <= '0;
      full_reg  <= 1'b0;
    end else begin
      digit_reg <= digit_next;
      valid_reg <= valid_next;
      count_reg <= count_next;
      full_reg  <= (count_next == COUNT_MAX);
    end
  end

  // Prescaler and digit index run freely; entry activity never touches them.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      presc_reg <= '0;
      idx_reg   <= '0;
    end else if (presc_reg == PRESC_LAST) begin
      presc_reg <= '0;
      idx_reg   <= idx_reg + 2'd1;
    end else begin
      presc_reg <= presc_reg + 1'b1;
    end
  end

  assign lit_digit = digit_reg[idx_reg];
  assign lit_valid = valid_reg[idx_reg];

  hex_to_seven u_dec (
    .digit (lit_digit),
    .seg   (dec_seg)
  );

  // Registered from the current index and buffer, so a write to the lit
  // digit shows its new pattern on the very next cycle.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      an_reg  <= AN_OFF;
      seg_reg <= SEG_BLANK;
    end else if (lit_valid) begin
      an_reg  <= ~(4'b0001 << idx_reg);
      seg_reg <= dec_seg;
    end else begin
      an_reg  <= AN_OFF;
      seg_reg <= SEG_BLANK;
    end
  end

  assign bus.code      = digit_reg;
  assign bus.count     = count_reg;
  assign bus.full      = full_reg;
  assign bus.AN        = an_reg;
  assign bus.seven_out = seg_reg;

endmodule

// File: tb/tb_digit_entry_display.sv
// tb_digit_entry_display: scoreboard bench for digit_entry_display at
// REFRESH_DIV=4. Stimulus pushes expected buffer/display values tagged with
// the cycle number at which they must hold; a negedge monitor pops and checks.
module tb_digit_entry_display;

  logic clk_in = 1'b0;
  logic rst    = 1'b1;

  digit_entry_display_if bus ();

  digit_entry_display #(.REFRESH_DIV(4)) dut (
    .clk_in (clk_in),
    .rst    (rst),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int          cyc;
    bit          is_disp;
    logic [15:0] code;
    logic [2:0]  count;
    logic        full;
    logic [3:0]  an;
    logic [6:0]  seg;
  } exp_t;

  exp_t sb_q[$];
  exp_t e;
  int   total = 0;
  int   bad   = 0;
  int   cyc;

  // Hand-written per-index display table for the frame under test.
  logic [3:0] an_tab  [4];
  logic [6:0] seg_tab [4];

  // Cycles since reset release; after edge k the monitor sees cyc == k.
  always @(posedge clk_in or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic check(string name, int k, logic [15:0] act, logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, k, act, exp);
    end
  endtask

  always @(negedge clk_in) begin
    if (!rst) begin
      while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
        e = sb_q.pop_front();
        if (e.cyc < cyc) begin
          total++;
          bad++;
          $display("FAIL missed_check cyc=%0d actual=%0d required=%0d", e.cyc, cyc, e.cyc);
        end else if (e.is_disp) begin
          check("AN", cyc, 16'(bus.AN), 16'(e.an));
          check("seven_out", cyc, 16'(bus.seven_out), 16'(e.seg));
        end else begin
          check("code", cyc, bus.code, e.code);
          check("count", cyc, 16'(bus.count), 16'(e.count));
          check("full", cyc, 16'(bus.full), 16'(e.full));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic push_buf(int k, logic [15:0] c, logic [2:0] n, logic f);
    exp_t x;
    x = '{cyc: k, is_disp: 1'b0, code: c, count: n, full: f, an: 4'h0, seg: 7'h0};
    sb_q.push_back(x);
  endtask

  task automatic push_disp(int k, logic [3:0] a, logic [6:0] s);
    exp_t x;
    x = '{cyc: k, is_disp: 1'b1, code: 16'h0, count: 3'd0, full: 1'b0, an: a, seg: s};
    sb_q.push_back(x);
  endtask

  // Display at cycle k shows the index held after edge k-1.
  task automatic push_frame(int k0, int k1);
    for (int k = k0; k <= k1; k++) begin
      push_disp(k, an_tab[((k - 1) / 4) % 4], seg_tab[((k - 1) / 4) % 4]);
    end
  endtask

  task automatic write(logic [3:0] d, logic [15:0] c, logic [2:0] n, logic f);
    bus.ent = 1'b1;
    bus.sw  = d;
    step();
    bus.ent = 1'b0;
    push_buf(cyc, c, n, f);
    $display("write sw=%h -> expect code=%h count=%0d full=%0d", d, c, n, f);
  endtask

  task automatic wait_until(int k);
    int g = 0;
    while (cyc < k && g < 200) begin
      step();
      g++;
    end
  endtask

  task automatic drain();
    int g = 0;
    while (sb_q.size() > 0 && g < 100) begin
      step();
      g++;
    end
    if (sb_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout actual=%0d required=0 pending checks", sb_q.size());
      sb_q.delete();
    end
  endtask

  initial begin
    int c;
    int g;
    bus.clr = 1'b0;
    bus.ent = 1'b0;
    bus.sw  = 4'h0;
    rst     = 1'b1;
    repeat (3) @(posedge clk_in);
    #1 rst = 1'b0;
    $display("reset released");

    // Reset state holds while idle.
    for (int k = 1; k <= 6; k++) begin
      push_buf(k, 16'h0000, 3'd0, 1'b0);
      push_disp(k, 4'b1111, 7'h7F);
    end
    wait_until(6);

    // Entry 1,2,3,4.
    write(4'h1, 16'h0001, 3'd1, 1'b0);
    write(4'h2, 16'h0012, 3'd2, 1'b0);
    write(4'h3, 16'h0123, 3'd3, 1'b0);
    write(4'h4, 16'h1234, 3'd4, 1'b1);
    c = cyc;
    an_tab  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    seg_tab = '{7'h19, 7'h30, 7'h24, 7'h79};
    push_frame(c + 1, c + 16);
    wait_until(c + 16);

    // Rollover.
    write(4'hA, 16'h234A, 3'd4, 1'b1);

    // Clear, then partial entry.
    bus.clr = 1'b1;
    step();
    bus.clr = 1'b0;
    push_buf(cyc, 16'h0000, 3'd0, 1'b0);
    $display("clear -> expect code=0000 count=0");
    write(4'hF, 16'h000F, 3'd1, 1'b0);
    c = cyc;
    an_tab  = '{4'b1110, 4'b1111, 4'b1111, 4'b1111};
    seg_tab = '{7'h0E, 7'h7F, 7'h7F, 7'h7F};
    push_frame(c + 1, c + 16);
    wait_until(c + 16);

    // Clear priority over a simultaneous ent.
    bus.clr = 1'b1;
    bus.ent = 1'b1;
    bus.sw  = 4'h5;
    step();
    bus.clr = 1'b0;
    bus.ent = 1'b0;
    push_buf(cyc, 16'h0000, 3'd0, 1'b0);
    $display("clr+ent sw=5 -> expect code=0000 count=0");
    write(4'h5, 16'h0005, 3'd1, 1'b0);

    // Fill the buffer again.
    write(4'h1, 16'h0051, 3'd2, 1'b0);
    write(4'h2, 16'h0512, 3'd3, 1'b0);
    write(4'h3, 16'h5123, 3'd4, 1'b1);
    write(4'h4, 16'h1234, 3'd4, 1'b1);
    drain();

    // Async reset at prescaler=2, index=2 (after edge k with k%16==10).
    g = 0;
    while (cyc % 16 != 10 && g < 40) begin
      step();
      g++;
    end
    #2 rst = 1'b1;
    #1;
    $display("async reset asserted mid-frame");
    check("async_code", cyc, bus.code, 16'h0000);
    check("async_count", cyc, 16'(bus.count), 16'd0);
    check("async_full", cyc, 16'(bus.full), 16'd0);
    check("async_AN", cyc, 16'(bus.AN), 16'h000F);
    check("async_seven_out", cyc, 16'(bus.seven_out), 16'h007F);
    step();
    step();
    rst = 1'b0;

    // First lit digit after release is index 0.
    write(4'h7, 16'h0007, 3'd1, 1'b0);
    push_disp(1, 4'b1111, 7'h7F);
    an_tab  = '{4'b1110, 4'b1111, 4'b1111, 4'b1111};
    seg_tab = '{7'h78, 7'h7F, 7'h7F, 7'h7F};
    push_frame(2, 16);
    wait_until(16);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
